// File: rtl/eyeriss_rlc_pkg.sv
// eyeriss_rlc_pkg: RLC word geometry, FSM states and pair field offsets shared by
// the global-buffer read decoder and the write-back encoder.
package eyeriss_rlc_pkg;
    localparam int DATA_WIDTH = 16;
    localparam int RUN_WIDTH  = 5;
    localparam int PAIRS      = 3;
    localparam int WORD_WIDTH = PAIRS * (RUN_WIDTH + DATA_WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RD, CAP, EMIT} state_e;

    function automatic int pair_lsb(input int k, input int run_w, input int data_w);
        return k * (run_w + data_w);
    endfunction
endpackage

// File: rtl/rlc_pair_sel.sv
// rlc_pair_sel: picks one (run, level) pair out of an RLC word and flags padding pairs.
module rlc_pair_sel #(
    parameter int DATA_WIDTH = eyeriss_rlc_pkg::DATA_WIDTH,
    parameter int RUN_WIDTH  = eyeriss_rlc_pkg::RUN_WIDTH,
    parameter int PAIRS      = eyeriss_rlc_pkg::PAIRS,
    parameter int IW         = 2
) (
    input  logic [PAIRS*(RUN_WIDTH+DATA_WIDTH)-1:0] word_i,
    input  logic [IW-1:0]                           idx_i,
    output logic [RUN_WIDTH-1:0]                    run_o,
    output logic [DATA_WIDTH-1:0]                   level_o,
    output logic                                    pad_o
);
    import eyeriss_rlc_pkg::*;

    localparam int PW = RUN_WIDTH + DATA_WIDTH;

    logic [PW-1:0] pair;

    // Indices past the last pair read as padding.
    always_comb begin
        pair = '0;
        for (int k = 0; k < PAIRS; k++)
            if (idx_i == IW'(k)) pair = word_i[pair_lsb(k, RUN_WIDTH, DATA_WIDTH) +: PW];
    end

    assign run_o   = pair[RUN_WIDTH-1:0];
    assign level_o = pair[RUN_WIDTH +: DATA_WIDTH];
    assign pad_o   = pair == '0;
endmodule

// File: rtl/rlc_rd_decoder.sv
// rlc_rd_decoder: reads one buffer word per accepted address and streams it to the
// PE array as raw 16-bit values or as run-length decoded values.
module rlc_rd_decoder #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = eyeriss_rlc_pkg::DATA_WIDTH,
    parameter int RUN_WIDTH  = eyeriss_rlc_pkg::RUN_WIDTH,
    parameter int PAIRS      = eyeriss_rlc_pkg::PAIRS,
    localparam int WORD_WIDTH = PAIRS * (RUN_WIDTH + DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] ADDR,
    input  logic                  ADD_VALID,
    input  logic                  ENCODE,
    output logic                  ADDR_READY,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [WORD_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_last
);
    import eyeriss_rlc_pkg::*;

    localparam int PW    = RUN_WIDTH + DATA_WIDTH;
    localparam int RAW_N = WORD_WIDTH / DATA_WIDTH;
    localparam int IDX_N = PAIRS > RAW_N ? PAIRS : RAW_N;
    localparam int IW    = IDX_N > 1 ? $clog2(IDX_N) : 1;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  mode_q;
    logic [WORD_WIDTH-1:0] word_q;
    logic [IW-1:0]         idx_q, last_q, last_d;
    logic [RUN_WIDTH-1:0]  cnt_q, run;
    logic [DATA_WIDTH-1:0] level, raw_val;
    logic                  pad, in_run, hs, adv, end_idx;

    rlc_pair_sel #(
        .DATA_WIDTH(DATA_WIDTH),
        .RUN_WIDTH (RUN_WIDTH),
        .PAIRS     (PAIRS),
        .IW        (IW)
    ) u_sel (
        .word_i (word_q[WORD_WIDTH-2:0]),
        .idx_i  (idx_q),
        .run_o  (run),
        .level_o(level),
        .pad_o  (pad)
    );

    always_comb begin
        raw_val = '0;
        for (int k = 0; k < RAW_N; k++)
            if (idx_q == IW'(k)) raw_val = word_q[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // Highest non-padding pair is the only one allowed to carry dout_last.
    always_comb begin
        last_d = '0;
        for (int k = 0; k < PAIRS; k++)
            if (mem_rdata[pair_lsb(k, RUN_WIDTH, DATA_WIDTH) +: PW] != '0) last_d = IW'(k);
    end

    assign in_run     = cnt_q != run;
    assign dout_valid = state_q == EMIT && (!mode_q || !pad);
    assign dout       = !dout_valid ? '0 : !mode_q ? raw_val : in_run ? '0 : level;
    assign dout_last  = dout_valid && mode_q && !in_run && word_q[WORD_WIDTH-1] && idx_q == last_q;
    assign hs         = dout_valid && dout_ready;
    assign adv        = (mode_q && pad) || (hs && !(mode_q && in_run));
    assign end_idx    = idx_q == (mode_q ? IW'(PAIRS-1) : IW'(RAW_N-1));
    assign ADDR_READY = state_q == IDLE;
    assign mem_rd_en  = state_q == RD;
    assign mem_addr   = addr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            mode_q  <= 1'b0;
            word_q  <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (ADD_VALID) begin
                    addr_q  <= ADDR;
                    mode_q  <= ENCODE;
                    state_q <= RD;
                end
                RD: state_q <= CAP;
                CAP: begin
                    word_q  <= mem_rdata;
                    last_q  <= last_d;
                    idx_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= EMIT;
                end
                EMIT: begin
                    if (hs && mode_q && in_run) cnt_q <= cnt_q + 1'b1;
                    if (adv) begin
                        idx_q <= idx_q + 1'b1;
                        cnt_q <= '0;
                        if (end_idx) state_q <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rlc_rd_decoder.sv
// tb_rlc_rd_decoder: table-driven scoreboard bench for the RLC read decoder.
module tb_rlc_rd_decoder;
    typedef struct packed {
        logic             enc;
        logic [63:0]      word;
        int               n;
        logic [0:7][15:0] v;
        logic [0:7]       lm;
        int               fv;
        int               lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ADDR;
    logic        ADD_VALID, ENCODE, ADDR_READY;
    logic        mem_rd_en;
    logic [7:0]  mem_addr;
    logic [63:0] mem_rdata;
    logic [15:0] dout;
    logic        dout_valid, dout_ready, dout_last;

    logic [63:0] mem [256];
    logic [16:0] q [$];
    logic [16:0] e;
    vec_t        tbl [8];
    int          errors = 0, checks = 0;
    int          cyc, tacc, first_rel, rd_cnt, rd_rel, hs_cnt, bp_mode, bp_cnt;
    logic        stall = 1'b0;
    logic [15:0] p_dout;
    logic        p_last;

    rlc_rd_decoder dut (
        .clk(clk), .rst(rst), .ADDR(ADDR), .ADD_VALID(ADD_VALID), .ENCODE(ENCODE),
        .ADDR_READY(ADDR_READY), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .dout_last(dout_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    function automatic logic [63:0] mk(input logic t, input logic [4:0] r2, input logic [15:0] l2,
                                       input logic [4:0] r1, input logic [15:0] l1,
                                       input logic [4:0] r0, input logic [15:0] l0);
        return {t, l2, r2, l1, r1, l0, r0};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic send(input logic [7:0] a, input logic enc);
        int n = 0;
        @(negedge clk);
        ADDR = a; ENCODE = enc; ADD_VALID = 1'b1;
        while (!ADDR_READY && n < 100) begin @(negedge clk); n++; end
        chk("accept_ready", ADDR_READY, 1);
        @(posedge clk); #1;
        tacc = cyc; first_rel = -1; rd_cnt = 0; hs_cnt = 0;
        ADD_VALID = 1'b0; ADDR = '0; ENCODE = 1'b0;
    endtask

    task automatic wait_ready(output int rel);
        int n = 0;
        rel = -1;
        while (n < 200) begin
            @(negedge clk); n++;
            if (ADDR_READY) begin rel = cyc - tacc + 1; break; end
        end
        chk("ready_returns", ADDR_READY, 1);
    endtask

    task automatic run_vec(input int i, input bit chk_lat);
        int r;
        for (int j = 0; j < tbl[i].n; j++) q.push_back({tbl[i].lm[j], tbl[i].v[j]});
        send(8'(i), tbl[i].enc);
        wait_ready(r);
        if (chk_lat) chk($sformatf("ready_latency[%0d]", i), r, tbl[i].lat);
        chk($sformatf("first_valid[%0d]", i), first_rel, tbl[i].fv);
        chk($sformatf("rd_pulses[%0d]", i), rd_cnt, 1);
        chk($sformatf("rd_cycle[%0d]", i), rd_rel, 1);
        chk($sformatf("drained[%0d]", i), q.size(), 0);
    endtask

    initial begin
        int r, n;
        rst = 1'b0; ADDR = '0; ADD_VALID = 1'b0; ENCODE = 1'b0; dout_ready = 1'b1; bp_mode = 0;
        tbl[0] = '{enc:1'b1, word:mk(1, 1, 16'h33, 0, 16'h22, 2, 16'h11), n:6,
                   v:{16'h0, 16'h0, 16'h11, 16'h22, 16'h0, 16'h33, 16'h0, 16'h0}, lm:8'b00000100, fv:3, lat:9};
        tbl[1] = '{enc:1'b0, word:64'h0004_0003_0002_0001, n:4,
                   v:{16'h1, 16'h2, 16'h3, 16'h4, 16'h0, 16'h0, 16'h0, 16'h0}, lm:8'b0, fv:3, lat:7};
        tbl[2] = '{enc:1'b1, word:mk(1, 0, 16'h0, 3, 16'hAA, 0, 16'h0), n:4,
                   v:{16'h0, 16'h0, 16'h0, 16'hAA, 16'h0, 16'h0, 16'h0, 16'h0}, lm:8'b00010000, fv:4, lat:9};
        tbl[3] = '{enc:1'b1, word:mk(0, 2, 16'hC, 0, 16'hB, 0, 16'hA), n:5,
                   v:{16'hA, 16'hB, 16'h0, 16'h0, 16'hC, 16'h0, 16'h0, 16'h0}, lm:8'b0, fv:3, lat:8};
        tbl[4] = '{enc:1'b1, word:mk(1, 0, 16'h0, 0, 16'h0, 0, 16'h0), n:0,
                   v:'0, lm:8'b0, fv:-1, lat:6};
        tbl[5] = '{enc:1'b1, word:mk(1, 0, 16'h0, 1, 16'hBB, 0, 16'hAA), n:3,
                   v:{16'hAA, 16'h0, 16'hBB, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, lm:8'b00100000, fv:3, lat:7};
        tbl[6] = '{enc:1'b0, word:64'hFFFF_8000_1234_ABCD, n:4,
                   v:{16'hABCD, 16'h1234, 16'h8000, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0}, lm:8'b0, fv:3, lat:7};
        tbl[7] = '{enc:1'b1, word:mk(1, 0, 16'h0, 0, 16'h0, 2, 16'h0), n:3,
                   v:'0, lm:8'b00100000, fv:3, lat:8};
        for (int i = 0; i < 8; i++) mem[i] = tbl[i].word;
        mem[20] = mk(1, 0, 16'h0, 0, 16'h0, 31, 16'h0101);
        fork
            forever begin
                @(negedge clk);
                if (rst) begin
                    if (mem_rd_en) begin rd_cnt++; rd_rel = cyc - tacc + 1; end
                    if (stall) begin
                        chk("stall_valid", dout_valid, 1);
                        chk("stall_dout", dout, p_dout);
                        chk("stall_last", dout_last, p_last);
                    end
                    if (dout_valid && first_rel < 0) first_rel = cyc - tacc + 1;
                    if (dout_valid && dout_ready) begin
                        hs_cnt++;
                        if (q.size() == 0) chk("unexpected_value", q.size(), 1);
                        else begin
                            e = q.pop_front();
                            chk("dout", dout, e[15:0]);
                            chk("dout_last", dout_last, e[16]);
                        end
                    end
                    stall = dout_valid && !dout_ready;
                    p_dout = dout; p_last = dout_last;
                end else stall = 1'b0;
            end
            forever begin
                @(posedge clk); #1;
                bp_cnt++;
                dout_ready = bp_mode == 0 ? 1'b1 : bp_mode == 1 ? (bp_cnt % 4 == 0 || bp_cnt % 4 == 3)
                                                                 : 1'($urandom_range(1, 0));
            end
        join_none
        #1;
        chk("rst_ready", ADDR_READY, 1);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_last", dout_last, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int p = 0; p < 3; p++) begin
            bp_mode = p;
            for (int i = 0; i < 8; i++) run_vec(i, p == 0);
        end
        bp_mode = 0;
        for (int j = 0; j < 31; j++) q.push_back(17'h0);
        q.push_back({1'b1, 16'h0101});
        send(8'd20, 1'b1);
        wait_ready(r);
        chk("maxrun_latency", r, 37);
        chk("maxrun_drained", q.size(), 0);
        for (int j = 0; j < tbl[0].n; j++) q.push_back({tbl[0].lm[j], tbl[0].v[j]});
        send(8'd0, 1'b1);
        n = 0;
        while (hs_cnt < 2 && n < 50) begin @(negedge clk); #1; n++; end
        chk("midword_handshakes", hs_cnt, 2);
        rst = 1'b0; ADD_VALID = 1'b1; ADDR = 8'hFF; ENCODE = 1'b1;
        #1;
        chk("mid_rst_dout", dout, 0);
        chk("mid_rst_valid", dout_valid, 0);
        chk("mid_rst_last", dout_last, 0);
        chk("mid_rst_rd_en", mem_rd_en, 0);
        chk("mid_rst_mem_addr", mem_addr, 0);
        chk("mid_rst_ready", ADDR_READY, 1);
        q.delete();
        @(posedge clk); #1;
        chk("rst_ignores_addr", mem_addr, 0);
        chk("rst_ignores_valid", mem_rd_en, 0);
        @(negedge clk);
        ADD_VALID = 1'b0; ADDR = '0; ENCODE = 1'b0;
        #1 rst = 1'b1;
        run_vec(0, 1'b1);
        repeat (3) @(negedge clk);
        chk("final_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rlc_rd_decoder.md
# rlc_rd_decoder

Read-side responder for the address generator on the global-buffer read path. It accepts one address per handshake, issues a synchronous read to the 1-cycle-latency buffer SRAM, and captures the returned 64-bit word. It streams the word's contents to the PE array as 16-bit values, either raw or run-length decoded. The RLC format is the Eyeriss format: 3 pairs of (5-bit zero-run, 16-bit level) plus a term bit.

## Interface
Parameters:
- ADDR_WIDTH, 8, width of ADDR / mem_addr
- DATA_WIDTH, 16, width of one output value and one RLC level
- RUN_WIDTH, 5, width of one RLC zero-run field
- PAIRS, 3, RLC pairs per word
- WORD_WIDTH, PAIRS*(RUN_WIDTH+DATA_WIDTH)+1 = 64, derived localparam, not overridable

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  clock; all state on rising edge
  - rst  in  1  asynchronous, active-low reset
- Address side:
  - ADDR  in  ADDR_WIDTH  read address from the address generator
  - ADD_VALID  in  1  ADDR valid
  - ENCODE  in  1  word at ADDR is RLC-encoded; sampled with ADDR
  - ADDR_READY  out  1  address accepted when ADD_VALID && ADDR_READY; drives the generator's en
- SRAM side:
  - mem_rd_en  out  1  SRAM read strobe
  - mem_addr  out  ADDR_WIDTH  SRAM address
  - mem_rdata  in  WORD_WIDTH  SRAM data, valid the cycle after mem_rd_en
- Output stream:
  - dout  out  DATA_WIDTH  output value
  - dout_valid  out  1  dout valid
  - dout_ready  in  1  consumer ready
  - dout_last  out  1  final value of an RLC series, from the term bit

## Operation
- FSM states:
  - IDLE: ADDR_READY=1. On accept, register ADDR into mem_addr and ENCODE into the mode register, then go to RD.
  - RD: mem_rd_en=1 for exactly one cycle, then go to CAP.
  - CAP: register mem_rdata into the word register, precompute the last non-padding pair index, clear counters, then go to EMIT.
  - EMIT: stream values. After the final handshake of the word, go to IDLE.
- ADDR_READY is 1 only in IDLE. No second address is accepted while a word is in flight.
- RLC word layout:
  - Pair k occupies bits [k*21 +: 21]: run = bits [4:0], level = bits [20:5].
  - Term bit = bit WORD_WIDTH-1.
- Encoded mode, per pair k = 0..PAIRS-1:
  - Emit `run` zeros, then the level.
  - Each value advances only on the dout_valid && dout_ready handshake.
  - A padding pair (run=0, level=0) takes one cycle with dout_valid=0 and emits nothing.
- dout_last=1 only on the level of the highest-index non-padding pair, and only when the term bit is 1. An all-padding word emits nothing and never asserts dout_last.
- Raw mode: emit WORD_WIDTH/DATA_WIDTH = 4 values, bits [15:0] first. The term bit is ignored and dout_last=0.
- Run counter is RUN_WIDTH bits and compares against run. Run=31 gives 31 zeros then the level, with no wrap.
- While dout_valid && !dout_ready, dout, dout_valid and dout_last hold stable.
- Reset, including mid-EMIT: go to IDLE and clear the word register and counters. The partial word is discarded with no further output.

## Timing
- Accept edge T. Then:
  - mem_rd_en=1 during cycle T+1.
  - mem_rdata sampled at the end of T+2.
  - First dout_valid at T+3.
- Steady state: 1 value/cycle with dout_ready held high. Padding costs 1 idle cycle per padding pair.
- Next ADDR_READY: the cycle after the final handshake, i.e. 3 cycles of overhead per word.
- Reset values:
  - FSM in IDLE, so ADDR_READY=1, also while rst is low.
  - mem_rd_en=0, mem_addr=0, dout=0, dout_valid=0, dout_last=0.
- Inputs are ignored while rst is low.

## Structure
- Shared package eyeriss_rlc_pkg holds:
  - DATA_WIDTH, RUN_WIDTH, PAIRS, WORD_WIDTH
  - state enum {IDLE, RD, CAP, EMIT}
  - the pair field-offset function
- The encoder on the write-back path imports the same package.
- One sub-module, rlc_pair_sel: combinational; given the word and a pair index, returns run, level and is_padding.

## Test plan
- Encoded, word {term=1, p2=(1,0x0033), p1=(0,0x0022), p0=(2,0x0011)}, dout_ready=1 -> dout 0,0,0x0011,0x0022,0,0x0033 on 6 consecutive cycles from T+3; dout_last only on 0x0033; ADDR_READY back at T+9.
- Raw, ENCODE=0, mem_rdata=0x0004_0003_0002_0001 -> dout 1,2,3,4; dout_last=0 throughout.
- Backpressure: same encoded word, dout_ready toggling 1,0,0,1,... -> identical value sequence, each value held stable while stalled, no drop or duplicate.
- Padding: p2=(0,0), p1=(3,0x00AA), p0=(0,0), term=1 -> idle cycle, 0,0,0,0x00AA with dout_last, idle cycle, then IDLE.
- Max run: p0=(31,0x0101), others padding -> 31 zeros then 0x0101; no wrap.
- Reset: drop rst for one cycle mid-EMIT after the 2nd value -> all outputs 0, ADDR_READY=1; a new address then yields a full, correct word.
